// File: rtl/channel_interleaver_if.sv
// Stream bundle for channel_interleaver: two tready-less ADC inputs and one arbitrated AXIS output.
// master = interleaver side, slave = the surrounding splitter/DMA side.
interface channel_interleaver_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PORT1_tdata;
    logic                        S_AXIS_PORT1_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PORT2_tdata;
    logic                        S_AXIS_PORT2_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata;
    logic                        M_AXIS_tuser;
    logic                        M_AXIS_tvalid;
    logic                        M_AXIS_tready;

    modport master (
        input  S_AXIS_PORT1_tdata, S_AXIS_PORT1_tvalid,
        input  S_AXIS_PORT2_tdata, S_AXIS_PORT2_tvalid,
        input  M_AXIS_tready,
        output M_AXIS_tdata, M_AXIS_tuser, M_AXIS_tvalid
    );

    modport slave (
        output S_AXIS_PORT1_tdata, S_AXIS_PORT1_tvalid,
        output S_AXIS_PORT2_tdata, S_AXIS_PORT2_tvalid,
        output M_AXIS_tready,
        input  M_AXIS_tdata, M_AXIS_tuser, M_AXIS_tvalid
    );
endinterface

// File: rtl/channel_interleaver.sv
// Buffers two ADC sample streams in per-channel FIFOs and round-robins them onto one
// back-pressured AXIS output tagged with the source channel; overflow is counted per channel.
module channel_interleaver #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH_LOG2  = 3,
    parameter int DROP_COUNT_WIDTH = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        enable,
    input  logic [1:0]                  channel_mask,
    input  logic                        flush,
    channel_interleaver_if.master       axis,
    output logic [DROP_COUNT_WIDTH-1:0] overflow_count1,
    output logic [DROP_COUNT_WIDTH-1:0] overflow_count2
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    typedef logic [FIFO_DEPTH_LOG2:0]    ptr_t;
    typedef logic [AXIS_TDATA_WIDTH-1:0] data_t;
    typedef enum logic {GRANT_PORT1 = 1'b0, GRANT_PORT2 = 1'b1} grant_e;

    data_t                       mem [2][DEPTH];
    ptr_t                        wr_ptr [2];
    ptr_t                        rd_ptr [2];
    logic [DROP_COUNT_WIDTH-1:0] drop_count [2];
    grant_e                      last_grant;
    data_t                       out_data;
    logic                        out_user;
    logic                        out_valid;

    data_t      in_data [2];
    logic [1:0] in_valid;
    logic [1:0] full, empty, wr_req, wr_en, drop, pop;
    logic       load, pick_valid;
    grant_e     pick;
    data_t      rd_data;

    always_comb begin
        in_data[0]  = axis.S_AXIS_PORT1_tdata;
        in_data[1]  = axis.S_AXIS_PORT2_tdata;
        in_valid[0] = axis.S_AXIS_PORT1_tvalid;
        in_valid[1] = axis.S_AXIS_PORT2_tvalid;
        load        = (!out_valid || axis.M_AXIS_tready) && !flush;
        for (int unsigned n = 0; n < 2; n++) begin
            // Full is judged on the pointers at cycle start, so a same-cycle pop cannot rescue a write.
            full[n]   = (wr_ptr[n][FIFO_DEPTH_LOG2] != rd_ptr[n][FIFO_DEPTH_LOG2]) &&
                        (wr_ptr[n][FIFO_DEPTH_LOG2-1:0] == rd_ptr[n][FIFO_DEPTH_LOG2-1:0]);
            empty[n]  = (wr_ptr[n] == rd_ptr[n]);
            wr_req[n] = in_valid[n] && enable && channel_mask[n] && !flush;
            wr_en[n]  = wr_req[n] && !full[n];
            drop[n]   = wr_req[n] && full[n];
        end
        pick_valid = !(empty[0] && empty[1]);
        if (!empty[0] && !empty[1]) begin
            pick = (last_grant == GRANT_PORT1) ? GRANT_PORT2 : GRANT_PORT1;
        end else begin
            pick = empty[0] ? GRANT_PORT2 : GRANT_PORT1;
        end
        rd_data = mem[pick][rd_ptr[pick][FIFO_DEPTH_LOG2-1:0]];
        pop     = '0;
        if (load && pick_valid) begin
            pop[pick] = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        for (int unsigned n = 0; n < 2; n++) begin
            if (wr_en[n]) begin
                mem[n][wr_ptr[n][FIFO_DEPTH_LOG2-1:0]] <= in_data[n];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_user   <= 1'b0;
            last_grant <= GRANT_PORT2;
            for (int unsigned n = 0; n < 2; n++) begin
                wr_ptr[n]     <= '0;
                rd_ptr[n]     <= '0;
                drop_count[n] <= '0;
            end
        end else begin
            if (load) begin
                out_valid <= pick_valid;
                if (pick_valid) begin
                    out_data   <= rd_data;
                    out_user   <= pick;
                    last_grant <= pick;
                end
            end else if (out_valid && axis.M_AXIS_tready) begin
                // Flush cycle with a handshake: the held word leaves but nothing replaces it.
                out_valid <= 1'b0;
            end
            for (int unsigned n = 0; n < 2; n++) begin
                if (flush) begin
                    wr_ptr[n]     <= '0;
                    rd_ptr[n]     <= '0;
                    drop_count[n] <= '0;
                end else begin
                    if (wr_en[n]) wr_ptr[n] <= wr_ptr[n] + 1'b1;
                    if (pop[n])   rd_ptr[n] <= rd_ptr[n] + 1'b1;
                    if (drop[n] && (drop_count[n] != '1)) begin
                        drop_count[n] <= drop_count[n] + 1'b1;
                    end
                end
            end
        end
    end

    assign axis.M_AXIS_tdata  = out_data;
    assign axis.M_AXIS_tuser  = out_user;
    assign axis.M_AXIS_tvalid = out_valid;
    assign overflow_count1    = drop_count[0];
    assign overflow_count2    = drop_count[1];
endmodule

// File: tb/tb_channel_interleaver.sv
// Scoreboard bench for channel_interleaver: a queue-based reference predicts every output word,
// plus a second instance with 4-bit drop counters shares the stimulus to exercise saturation.
module tb_channel_interleaver;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic [1:0]  channel_mask;
    logic        flush;
    logic [15:0] ovf1, ovf2;
    logic [3:0]  sat1, sat2;

    channel_interleaver_if #(.AXIS_TDATA_WIDTH(32)) axis ();
    channel_interleaver_if #(.AXIS_TDATA_WIDTH(32)) axis_sat ();

    assign axis_sat.S_AXIS_PORT1_tdata  = axis.S_AXIS_PORT1_tdata;
    assign axis_sat.S_AXIS_PORT1_tvalid = axis.S_AXIS_PORT1_tvalid;
    assign axis_sat.S_AXIS_PORT2_tdata  = axis.S_AXIS_PORT2_tdata;
    assign axis_sat.S_AXIS_PORT2_tvalid = axis.S_AXIS_PORT2_tvalid;
    assign axis_sat.M_AXIS_tready       = axis.M_AXIS_tready;

    always #4 aclk = ~aclk;

    channel_interleaver #(
        .AXIS_TDATA_WIDTH(32), .FIFO_DEPTH_LOG2(3), .DROP_COUNT_WIDTH(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .channel_mask(channel_mask),
        .flush(flush), .axis(axis), .overflow_count1(ovf1), .overflow_count2(ovf2)
    );

    channel_interleaver #(
        .AXIS_TDATA_WIDTH(32), .FIFO_DEPTH_LOG2(3), .DROP_COUNT_WIDTH(4)
    ) dut_sat (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .channel_mask(channel_mask),
        .flush(flush), .axis(axis_sat), .overflow_count1(sat1), .overflow_count2(sat2)
    );

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int unsigned hs_cnt = 0;
    int unsigned hs_user1 = 0;

    logic [32:0] exp_q [$];
    logic [31:0] mf0 [$];
    logic [31:0] mf1 [$];
    logic        m_valid;
    logic        m_last;
    int unsigned m_cnt [2];
    int unsigned m_sat [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        mf0.delete();
        mf1.delete();
        exp_q.delete();
        m_valid = 1'b0;
        m_last  = 1'b1;
        m_cnt   = '{0, 0};
        m_sat   = '{0, 0};
    endtask

    task automatic count_drop(input int unsigned n);
        if (m_cnt[n] < 65535) m_cnt[n]++;
        if (m_sat[n] < 15) m_sat[n]++;
    endtask

    task automatic model_update(input logic v1, input logic v2, input logic [31:0] d1,
                                input logic [31:0] d2, input logic rdy, input logic fl);
        int unsigned sz0, sz1;
        logic        load, pick;
        logic [31:0] word;
        sz0  = mf0.size();
        sz1  = mf1.size();
        load = (!m_valid || rdy) && !fl;
        if (load) begin
            if (sz0 == 0 && sz1 == 0) begin
                m_valid = 1'b0;
            end else begin
                if (sz0 != 0 && sz1 != 0) pick = !m_last;
                else pick = (sz0 == 0);
                if (pick) word = mf1.pop_front();
                else word = mf0.pop_front();
                exp_q.push_back({pick, word});
                m_valid = 1'b1;
                m_last  = pick;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (fl) begin
            mf0.delete();
            mf1.delete();
            m_cnt = '{0, 0};
            m_sat = '{0, 0};
        end else begin
            if (v1 && enable && channel_mask[0]) begin
                if (sz0 == 8) count_drop(0);
                else mf0.push_back(d1);
            end
            if (v2 && enable && channel_mask[1]) begin
                if (sz1 == 8) count_drop(1);
                else mf1.push_back(d2);
            end
        end
    endtask

    // Called at a falling edge; checks state left by the previous rising edge, then drives one cycle.
    task automatic step(input logic v1, input logic v2, input logic [31:0] d1,
                        input logic [31:0] d2, input logic rdy, input logic fl);
        logic [32:0] e;
        check_eq("tvalid", axis.M_AXIS_tvalid, m_valid);
        check_eq("ovf1", ovf1, m_cnt[0]);
        check_eq("ovf2", ovf2, m_cnt[1]);
        check_eq("sat1", sat1, m_sat[0]);
        check_eq("sat2", sat2, m_sat[1]);
        axis.S_AXIS_PORT1_tvalid = v1;
        axis.S_AXIS_PORT1_tdata  = d1;
        axis.S_AXIS_PORT2_tvalid = v2;
        axis.S_AXIS_PORT2_tdata  = d2;
        axis.M_AXIS_tready       = rdy;
        flush                    = fl;
        #1;
        if (axis.M_AXIS_tvalid && rdy) begin
            hs_cnt++;
            if (axis.M_AXIS_tuser) hs_user1++;
            check_eq("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("word", {axis.M_AXIS_tuser, axis.M_AXIS_tdata}, e);
            end
        end
        model_update(v1, v2, d1, d2, rdy, fl);
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic reset_pulse();
        axis.S_AXIS_PORT1_tvalid = 1'b0;
        axis.S_AXIS_PORT2_tvalid = 1'b0;
        flush   = 1'b0;
        aresetn = 1'b0;
        #1;
        check_eq("rst_tvalid", axis.M_AXIS_tvalid, 0);
        check_eq("rst_tdata", axis.M_AXIS_tdata, 0);
        check_eq("rst_tuser", axis.M_AXIS_tuser, 0);
        check_eq("rst_ovf1", ovf1, 0);
        check_eq("rst_ovf2", ovf2, 0);
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn = 1'b0;
        enable = 1'b0;
        channel_mask = 2'b00;
        flush = 1'b0;
        axis.S_AXIS_PORT1_tvalid = 1'b0;
        axis.S_AXIS_PORT1_tdata  = '0;
        axis.S_AXIS_PORT2_tvalid = 1'b0;
        axis.S_AXIS_PORT2_tdata  = '0;
        axis.M_AXIS_tready       = 1'b0;
        model_reset();
        @(negedge aclk);
        reset_pulse();

        // Both channels saturating the output: strict alternation, two-cycle first latency, drops.
        enable = 1'b1;
        channel_mask = 2'b11;
        step(1, 1, 32'h0000_0001, 32'hFFFF_FF00, 1, 0);
        check_eq("lat_cycle1_tvalid", axis.M_AXIS_tvalid, 0);
        step(1, 1, 32'h0000_0002, 32'hFFFF_FF01, 1, 0);
        check_eq("lat_cycle2_tvalid", axis.M_AXIS_tvalid, 1);
        check_eq("lat_first_word", {axis.M_AXIS_tuser, axis.M_AXIS_tdata}, {1'b0, 32'h0000_0001});
        for (int unsigned k = 2; k < 40; k++) step(1, 1, 32'h0000_0001 + k, 32'hFFFF_FF00 + k, 1, 0);
        for (int unsigned k = 0; k < 24; k++) step(0, 0, '0, '0, 1, 0);
        check_eq("t1_drained", exp_q.size(), 0);
        check_eq("t1_drops_seen", (ovf1 != 0) && (ovf2 != 0), 1);
        step(0, 0, '0, '0, 1, 1);

        // Only PORT1 enabled: 100 words in order, PORT2 traffic ignored and not counted.
        channel_mask = 2'b01;
        hs_cnt = 0;
        hs_user1 = 0;
        for (int unsigned k = 0; k < 100; k++) step(1, 1, 32'h0000_1000 + k, $urandom, 1, 0);
        for (int unsigned k = 0; k < 5; k++) step(0, 0, '0, '0, 1, 0);
        check_eq("t2_words", hs_cnt, 100);
        check_eq("t2_port2_words", hs_user1, 0);
        check_eq("t2_ovf1", ovf1, 0);
        check_eq("t2_ovf2", ovf2, 0);

        // Back-pressure: 8 per FIFO plus one held word, then a 17-word alternating drain.
        reset_pulse();
        channel_mask = 2'b11;
        for (int unsigned k = 0; k < 20; k++) begin
            step(1, 1, 32'hA000_0000 + k, 32'hB000_0000 + k, 0, 0);
            if (k >= 1) check_eq("t3_hold_data", axis.M_AXIS_tdata, 32'hA000_0000);
        end
        check_eq("t3_hold_user", axis.M_AXIS_tuser, 0);
        check_eq("t3_ovf1", ovf1, 11);
        check_eq("t3_ovf2", ovf2, 12);
        hs_cnt = 0;
        for (int unsigned k = 0; k < 30; k++) step(0, 0, '0, '0, 1, 0);
        check_eq("t3_drain_words", hs_cnt, 17);
        check_eq("t3_drain_idle", axis.M_AXIS_tvalid, 0);

        // Saturation: 4-bit counters stop at 15 while the 16-bit instance keeps counting.
        step(0, 0, '0, '0, 1, 1);
        for (int unsigned k = 0; k < 40; k++) step(1, 0, 32'hC000_0000 + k, '0, 0, 0);
        check_eq("t4_ovf1", ovf1, 31);
        check_eq("t4_sat1", sat1, 15);

        // Flush while a word is held under back-pressure.
        for (int unsigned k = 0; k < 12; k++) step(0, 0, '0, '0, 1, 0);
        for (int unsigned k = 0; k < 6; k++) step(k != 0, 1, 32'hD000_0000 + k, 32'hE000_0000 + k, 0, 0);
        step(1, 1, 32'hDEAD_0000, 32'hDEAD_0001, 0, 1);
        check_eq("t5_ovf1_cleared", ovf1, 0);
        check_eq("t5_held_valid", axis.M_AXIS_tvalid, 1);
        check_eq("t5_held_word", {axis.M_AXIS_tuser, axis.M_AXIS_tdata}, {1'b1, 32'hE000_0000});
        step(0, 0, '0, '0, 1, 0);
        check_eq("t5_idle_after", axis.M_AXIS_tvalid, 0);
        step(0, 0, '0, '0, 1, 0);
        check_eq("t5_sb_empty", exp_q.size(), 0);

        // Asynchronous reset mid-stream, then PORT1 wins first again.
        for (int unsigned k = 0; k < 10; k++) step(1, 1, 32'hF100_0000 + k, 32'hF200_0000 + k, 1, 0);
        check_eq("t6_pre_reset_valid", axis.M_AXIS_tvalid, 1);
        reset_pulse();
        step(1, 1, 32'h0000_0077, 32'h0000_0088, 1, 0);
        step(1, 1, 32'h0000_0078, 32'h0000_0089, 1, 0);
        check_eq("t6_first_word", {axis.M_AXIS_tuser, axis.M_AXIS_tdata}, {1'b0, 32'h0000_0077});
        for (int unsigned k = 0; k < 8; k++) step(0, 0, '0, '0, 1, 0);
        check_eq("t6_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
